mem_stage: RTL and testbench

- Memory (MEM) pipeline stage. Consumes the latched EX→MEM bundle: opcode, IR, PC, dest index/value, CC, vector dest, MAR/MDR, write enables, valid.
- Executes LDW/STW against a word-addressed data memory over MEM_LATENCY cycles, regenerating CC for loads.
- Drives the MEM→WB latch and a combinational stall back to FE/DE/EX.

---
 rtl/mem_stage_pkg.sv | 36 +++
 rtl/mem_stage_if.sv | 55 +++++
 rtl/mem_stage_data_mem.sv | 28 ++
 rtl/mem_stage.sv | 183 ++++++++++++++++++
 tb/tb_mem_stage.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Shared widths, opcodes, CC encodings and MEM FSM states for the MEM stage.
// Pure declarations; no logic, no latency, no backpressure.
package mem_stage_pkg;

    localparam int PC_WIDTH        = 32;
    localparam int IR_WIDTH        = 32;
    localparam int OPCODE_WIDTH    = 8;
    localparam int REG_WIDTH       = 32;
    localparam int VREG_ID_WIDTH   = 6;
    localparam int VREG_WIDTH      = 64;
    localparam int DMEM_ADDR_WIDTH = 10;

    localparam logic [OPCODE_WIDTH-1:0] OP_LDW = 8'h10;
    localparam logic [OPCODE_WIDTH-1:0] OP_STW = 8'h11;
    localparam logic [OPCODE_WIDTH-1:0] OP_LDB = 8'h12;
    localparam logic [OPCODE_WIDTH-1:0] OP_STB = 8'h13;

    localparam logic [2:0] CC_N = 3'b100;
    localparam logic [2:0] CC_Z = 3'b010;
    localparam logic [2:0] CC_P = 3'b001;

    typedef enum logic [0:0] {
        MEM_IDLE   = 1'b0,
        MEM_ACCESS = 1'b1
    } mem_state_e;

    function automatic logic [2:0] cc_of(input logic [REG_WIDTH-1:0] v);
        if (v[REG_WIDTH-1])
            return CC_N;
        else if (v == '0)
            return CC_Z;
        else
            return CC_P;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// EX->MEM latch inputs, MEM->WB latch outputs and the stall back to FE/DE/EX.
// master = upstream/WB side, slave = the MEM stage itself.
interface mem_stage_if;
    import mem_stage_pkg::*;

    logic                     I_LOCK;
    logic [PC_WIDTH-1:0]      I_PC;
    logic [IR_WIDTH-1:0]      I_IR;
    logic [OPCODE_WIDTH-1:0]  I_Opcode;
    logic [3:0]               I_DestRegIdx;
    logic [REG_WIDTH-1:0]     I_DestValue;
    logic [2:0]               I_CCValue;
    logic [VREG_ID_WIDTH-1:0] I_DestVRegIdx;
    logic [VREG_WIDTH-1:0]    I_VecDestValue;
    logic [REG_WIDTH-1:0]     I_MARValue;
    logic [REG_WIDTH-1:0]     I_MDRValue;
    logic                     I_EX_Valid;
    logic                     I_RegWEn;
    logic                     I_VRegWEn;
    logic                     I_CCWEn;

    logic                     O_LOCK;
    logic [PC_WIDTH-1:0]      O_PC;
    logic [IR_WIDTH-1:0]      O_IR;
    logic [OPCODE_WIDTH-1:0]  O_Opcode;
    logic [3:0]               O_DestRegIdx;
    logic [REG_WIDTH-1:0]     O_DestValue;
    logic [2:0]               O_CCValue;
    logic [VREG_ID_WIDTH-1:0] O_DestVRegIdx;
    logic [VREG_WIDTH-1:0]    O_VecDestValue;
    logic                     O_MEM_Valid;
    logic                     O_RegWEn;
    logic                     O_VRegWEn;
    logic                     O_CCWEn;
    logic                     O_MemStallSignal;

    modport master (
        output I_LOCK, I_PC, I_IR, I_Opcode, I_DestRegIdx, I_DestValue, I_CCValue,
               I_DestVRegIdx, I_VecDestValue, I_MARValue, I_MDRValue,
               I_EX_Valid, I_RegWEn, I_VRegWEn, I_CCWEn,
        input  O_LOCK, O_PC, O_IR, O_Opcode, O_DestRegIdx, O_DestValue, O_CCValue,
               O_DestVRegIdx, O_VecDestValue, O_MEM_Valid, O_RegWEn, O_VRegWEn,
               O_CCWEn, O_MemStallSignal
    );

    modport slave (
        input  I_LOCK, I_PC, I_IR, I_Opcode, I_DestRegIdx, I_DestValue, I_CCValue,
               I_DestVRegIdx, I_VecDestValue, I_MARValue, I_MDRValue,
               I_EX_Valid, I_RegWEn, I_VRegWEn, I_CCWEn,
        output O_LOCK, O_PC, O_IR, O_Opcode, O_DestRegIdx, O_DestValue, O_CCValue,
               O_DestVRegIdx, O_VecDestValue, O_MEM_Valid, O_RegWEn, O_VRegWEn,
               O_CCWEn, O_MemStallSignal
    );

endinterface

// File: rtl/mem_stage_data_mem.sv
// Word-organised data memory: byte-enabled write on the stage (falling) edge, async read.
// Read returns the pre-write word when a write lands on the same edge; never stalls.
module mem_stage_data_mem #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [3:0]    be_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(negedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b])
                    mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_stage.sv
// MEM stage: LDW/STW (LDB/STB with MEM_STAGE_BYTE_OPS_EN) held for MEM_LATENCY falling edges,
// pass-through ops take one edge; O_MemStallSignal freezes upstream while an access is pending.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DMEM_DEPTH  = 1 << DMEM_ADDR_WIDTH,
    parameter int MEM_LATENCY = 2
) (
    input logic        I_CLOCK,
    input logic        I_RESET,
    mem_stage_if.slave bus
);

    localparam int AW = $clog2(DMEM_DEPTH);
    localparam int CW = (MEM_LATENCY > 2) ? $clog2(MEM_LATENCY) : 1;

    mem_state_e           state_q;
    logic [CW-1:0]        cnt_q;
    logic                 is_ld, is_st, is_mem, is_load, is_store;
    logic                 stall, advance, mem_we;
    logic [AW-1:0]        word_idx;
    logic [1:0]           lane;
    logic [3:0]           mem_be;
    logic [31:0]          mem_wdata, mem_rdata;
    logic [REG_WIDTH-1:0] load_val;
    logic [REG_WIDTH-1:0] dest_value_d;
    logic [2:0]           cc_d;

    logic                     lock_q, valid_q, reg_wen_q, vreg_wen_q, cc_wen_q;
    logic [PC_WIDTH-1:0]      pc_q;
    logic [IR_WIDTH-1:0]      ir_q;
    logic [OPCODE_WIDTH-1:0]  opcode_q;
    logic [3:0]               dest_idx_q;
    logic [REG_WIDTH-1:0]     dest_value_q;
    logic [2:0]               cc_q;
    logic [VREG_ID_WIDTH-1:0] vdest_idx_q;
    logic [VREG_WIDTH-1:0]    vec_value_q;

    assign word_idx = bus.I_MARValue[AW+1:2];
    assign lane     = bus.I_MARValue[1:0];

`ifdef MEM_STAGE_BYTE_OPS_EN
    logic is_byte;
    logic [7:0] ld_byte;
    assign is_byte = (bus.I_Opcode == OP_LDB) || (bus.I_Opcode == OP_STB);
    assign is_ld   = (bus.I_Opcode == OP_LDW) || (bus.I_Opcode == OP_LDB);
    assign is_st   = (bus.I_Opcode == OP_STW) || (bus.I_Opcode == OP_STB);
    assign ld_byte = mem_rdata[8*lane +: 8];

    always_comb begin
        mem_be    = 4'b1111;
        mem_wdata = bus.I_MDRValue;
        load_val  = mem_rdata;
        if (is_byte) begin
            mem_be    = 4'b0001 << lane;
            mem_wdata = {4{bus.I_MDRValue[7:0]}};
            load_val  = {{(REG_WIDTH-8){ld_byte[7]}}, ld_byte};
        end
    end
`else
    logic unused_lane;
    assign unused_lane = ^lane;
    assign is_ld       = (bus.I_Opcode == OP_LDW);
    assign is_st       = (bus.I_Opcode == OP_STW);
    assign mem_be      = 4'b1111;
    assign mem_wdata   = bus.I_MDRValue;
    assign load_val    = mem_rdata;
`endif

    logic unused_mar;
    assign unused_mar = ^bus.I_MARValue[REG_WIDTH-1:AW+2];

    assign is_mem   = bus.I_EX_Valid && (is_ld || is_st);
    assign is_load  = is_mem && is_ld;
    assign is_store = is_mem && is_st;

    // Reset and lock-off both force the stage idle, so they also drop the stall.
    always_comb begin
        stall = 1'b0;
        if (bus.I_LOCK && !I_RESET) begin
            if (state_q == MEM_IDLE)
                stall = is_mem && (MEM_LATENCY > 1);
            else
                stall = (cnt_q != '0);
        end
    end

    assign advance = bus.I_LOCK && !stall;
    assign mem_we  = !I_RESET && advance && is_store;

    always_comb begin
        dest_value_d = bus.I_DestValue;
        cc_d         = bus.I_CCValue;
        if (is_load) begin
            dest_value_d = load_val;
            if (bus.I_CCWEn)
                cc_d = cc_of(load_val);
        end
    end

    mem_stage_data_mem #(
        .DEPTH (DMEM_DEPTH),
        .AW    (AW)
    ) u_dmem (
        .clk_i   (I_CLOCK),
        .we_i    (mem_we),
        .addr_i  (word_idx),
        .be_i    (mem_be),
        .wdata_i (mem_wdata),
        .rdata_o (mem_rdata)
    );

    always_ff @(negedge I_CLOCK) begin
        if (I_RESET) begin
            state_q      <= MEM_IDLE;
            cnt_q        <= '0;
            lock_q       <= 1'b0;
            valid_q      <= 1'b0;
            reg_wen_q    <= 1'b0;
            vreg_wen_q   <= 1'b0;
            cc_wen_q     <= 1'b0;
            pc_q         <= '0;
            ir_q         <= '0;
            opcode_q     <= '0;
            dest_idx_q   <= '0;
            dest_value_q <= '0;
            cc_q         <= '0;
            vdest_idx_q  <= '0;
            vec_value_q  <= '0;
        end else if (!bus.I_LOCK) begin
            state_q    <= MEM_IDLE;
            cnt_q      <= '0;
            lock_q     <= 1'b0;
            valid_q    <= 1'b0;
            reg_wen_q  <= 1'b0;
            vreg_wen_q <= 1'b0;
            cc_wen_q   <= 1'b0;
        end else if (stall) begin
            valid_q    <= 1'b0;
            reg_wen_q  <= 1'b0;
            vreg_wen_q <= 1'b0;
            cc_wen_q   <= 1'b0;
            if (state_q == MEM_IDLE) begin
                state_q <= MEM_ACCESS;
                cnt_q   <= CW'(MEM_LATENCY - 2);
            end else begin
                cnt_q <= cnt_q - CW'(1);
            end
        end else begin
            state_q      <= MEM_IDLE;
            cnt_q        <= '0;
            lock_q       <= 1'b1;
            valid_q      <= bus.I_EX_Valid;
            reg_wen_q    <= bus.I_RegWEn && bus.I_EX_Valid;
            vreg_wen_q   <= bus.I_VRegWEn && bus.I_EX_Valid;
            cc_wen_q     <= bus.I_CCWEn && bus.I_EX_Valid;
            pc_q         <= bus.I_PC;
            ir_q         <= bus.I_IR;
            opcode_q     <= bus.I_Opcode;
            dest_idx_q   <= bus.I_DestRegIdx;
            dest_value_q <= dest_value_d;
            cc_q         <= cc_d;
            vdest_idx_q  <= bus.I_DestVRegIdx;
            vec_value_q  <= bus.I_VecDestValue;
        end
    end

    assign bus.O_LOCK           = lock_q;
    assign bus.O_PC             = pc_q;
    assign bus.O_IR             = ir_q;
    assign bus.O_Opcode         = opcode_q;
    assign bus.O_DestRegIdx     = dest_idx_q;
    assign bus.O_DestValue      = dest_value_q;
    assign bus.O_CCValue        = cc_q;
    assign bus.O_DestVRegIdx    = vdest_idx_q;
    assign bus.O_VecDestValue   = vec_value_q;
    assign bus.O_MEM_Valid      = valid_q;
    assign bus.O_RegWEn         = reg_wen_q;
    assign bus.O_VRegWEn        = vreg_wen_q;
    assign bus.O_CCWEn          = cc_wen_q;
    assign bus.O_MemStallSignal = stall;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage at MEM_LATENCY=3; byte-op checks follow MEM_STAGE_BYTE_OPS_EN.
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam logic [7:0] OP_ADD = 8'h01;

    logic clk = 1'b1;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;
    logic [31:0] pc_ctr = 32'h100;
    int   ns, nb;

    mem_stage_if bus ();

    mem_stage #(
        .DMEM_DEPTH  (1024),
        .MEM_LATENCY (3)
    ) dut (
        .I_CLOCK (clk),
        .I_RESET (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] op, input logic [31:0] mar, input logic [31:0] mdr,
                         input logic vld, input logic rwen, input logic ccwen,
                         input logic [31:0] dval, input logic [2:0] cc);
        pc_ctr             = pc_ctr + 32'd4;
        bus.I_PC           = pc_ctr;
        bus.I_IR           = {op, 24'h00_0abc};
        bus.I_Opcode       = op;
        bus.I_DestRegIdx   = 4'd3;
        bus.I_DestValue    = dval;
        bus.I_CCValue      = cc;
        bus.I_DestVRegIdx  = 6'd5;
        bus.I_VecDestValue = 64'h0123_4567_89ab_cdef;
        bus.I_MARValue     = mar;
        bus.I_MDRValue     = mdr;
        bus.I_EX_Valid     = vld;
        bus.I_RegWEn       = rwen;
        bus.I_VRegWEn      = 1'b0;
        bus.I_CCWEn        = ccwen;
    endtask

    // Runs the currently driven op to its completion edge, counting stall cycles and bubbles.
    task automatic run_op(output int nstall, output int nbub);
        nstall = 0;
        nbub   = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            if (!bus.O_MemStallSignal) break;
            nstall++;
            tick();
            if (!bus.O_MEM_Valid && !bus.O_RegWEn && !bus.O_CCWEn) nbub++;
        end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.I_LOCK = 1'b1;
        drive(OP_LDW, 32'h10, 32'h5, 1'b1, 1'b1, 1'b1, 32'h77, CC_P);
        tick();
        tick();
        n_chk++; if (bus.O_LOCK !== 1'b0) begin n_fail++; $display("FAIL reset_lock: got %b want 0", bus.O_LOCK); end
        n_chk++; if (bus.O_MEM_Valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.O_MEM_Valid); end
        n_chk++; if (bus.O_DestValue !== 32'h0) begin n_fail++; $display("FAIL reset_dest: got %h want 0", bus.O_DestValue); end
        n_chk++; if (bus.O_PC !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", bus.O_PC); end
        rst = 1'b0;
        drive(OP_ADD, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 3'b000);
        tick();
    endtask

    task automatic test_store_load();
        drive(OP_STW, 32'h10, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 32'h0, CC_Z);
        run_op(ns, nb);
        n_chk++; if (bus.O_MEM_Valid !== 1'b1) begin n_fail++; $display("FAIL stw_valid: got %b want 1", bus.O_MEM_Valid); end
        drive(OP_LDW, 32'h10, 32'h0, 1'b1, 1'b1, 1'b1, 32'h1234, CC_P);
        run_op(ns, nb);
        n_chk++; if (bus.O_DestValue !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ldw_data: got %h want deadbeef", bus.O_DestValue); end
        n_chk++; if (bus.O_CCValue !== CC_N) begin n_fail++; $display("FAIL ldw_cc: got %b want 100", bus.O_CCValue); end
        n_chk++; if (bus.O_RegWEn !== 1'b1 || bus.O_CCWEn !== 1'b1) begin n_fail++; $display("FAIL ldw_wen: got %b%b want 11", bus.O_RegWEn, bus.O_CCWEn); end
        n_chk++; if (bus.O_PC !== pc_ctr) begin n_fail++; $display("FAIL ldw_pc: got %h want %h", bus.O_PC, pc_ctr); end
    endtask

    task automatic test_latency();
        drive(OP_LDW, 32'h10, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0, CC_Z);
        run_op(ns, nb);
        n_chk++; if (ns !== 2) begin n_fail++; $display("FAIL lat_stalls: got %0d want 2", ns); end
        n_chk++; if (nb !== 2) begin n_fail++; $display("FAIL lat_bubbles: got %0d want 2", nb); end
        n_chk++; if (bus.O_MEM_Valid !== 1'b1 || bus.O_DestValue !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL lat_done: got %b/%h want 1/deadbeef", bus.O_MEM_Valid, bus.O_DestValue); end
    endtask

    task automatic test_lock();
        bus.I_LOCK = 1'b0;
        drive(OP_LDW, 32'h20, 32'h0, 1'b1, 1'b1, 1'b0, 32'h55, CC_P);
        @(posedge clk);
        n_chk++; if (bus.O_MemStallSignal !== 1'b0) begin n_fail++; $display("FAIL lock_stall: got %b want 0", bus.O_MemStallSignal); end
        tick();
        n_chk++; if (bus.O_LOCK !== 1'b0 || bus.O_MEM_Valid !== 1'b0 || bus.O_RegWEn !== 1'b0) begin
            n_fail++; $display("FAIL lock_off: got %b%b%b want 000", bus.O_LOCK, bus.O_MEM_Valid, bus.O_RegWEn); end
        n_chk++; if (bus.O_DestValue !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lock_hold: got %h want deadbeef", bus.O_DestValue); end
        bus.I_LOCK = 1'b1;
        drive(OP_ADD, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h99, CC_P);
        tick();
        n_chk++; if (bus.O_LOCK !== 1'b1) begin n_fail++; $display("FAIL lock_on: got %b want 1", bus.O_LOCK); end
    endtask

    task automatic test_passthrough();
        drive(OP_ADD, 32'h10, 32'h0, 1'b1, 1'b1, 1'b1, 32'h55, CC_P);
        @(posedge clk);
        n_chk++; if (bus.O_MemStallSignal !== 1'b0) begin n_fail++; $display("FAIL pass_stall: got %b want 0", bus.O_MemStallSignal); end
        tick();
        n_chk++; if (bus.O_DestValue !== 32'h55 || bus.O_CCValue !== CC_P) begin
            n_fail++; $display("FAIL pass_data: got %h/%b want 55/001", bus.O_DestValue, bus.O_CCValue); end
        n_chk++; if (bus.O_Opcode !== OP_ADD || bus.O_DestRegIdx !== 4'd3 || bus.O_VecDestValue !== 64'h0123_4567_89ab_cdef) begin
            n_fail++; $display("FAIL pass_fields: got %h/%h/%h", bus.O_Opcode, bus.O_DestRegIdx, bus.O_VecDestValue); end
    endtask

    task automatic test_invalid_store();
        drive(OP_STW, 32'h20, 32'hCAFE0001, 1'b1, 1'b0, 1'b0, 32'h0, CC_Z);
        run_op(ns, nb);
        drive(OP_STW, 32'h20, 32'h5, 1'b0, 1'b1, 1'b0, 32'h0, CC_Z);
        @(posedge clk);
        n_chk++; if (bus.O_MemStallSignal !== 1'b0) begin n_fail++; $display("FAIL inv_stall: got %b want 0", bus.O_MemStallSignal); end
        tick();
        n_chk++; if (bus.O_MEM_Valid !== 1'b0 || bus.O_RegWEn !== 1'b0) begin
            n_fail++; $display("FAIL inv_valid: got %b%b want 00", bus.O_MEM_Valid, bus.O_RegWEn); end
        drive(OP_LDW, 32'h20, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0, CC_Z);
        run_op(ns, nb);
        n_chk++; if (bus.O_DestValue !== 32'hCAFE0001) begin n_fail++; $display("FAIL inv_mem: got %h want cafe0001", bus.O_DestValue); end
    endtask

    task automatic test_reset_mid();
        drive(OP_STW, 32'h30, 32'h77, 1'b1, 1'b0, 1'b0, 32'h0, CC_Z);
        run_op(ns, nb);
        drive(OP_STW, 32'h30, 32'h99, 1'b1, 1'b0, 1'b0, 32'h0, CC_Z);
        tick();
        rst = 1'b1;
        tick();
        n_chk++; if (bus.O_LOCK !== 1'b0 || bus.O_DestValue !== 32'h0 || bus.O_CCValue !== 3'b000 || bus.O_IR !== 32'h0) begin
            n_fail++; $display("FAIL rstmid_out: got %b/%h/%b/%h want zeros", bus.O_LOCK, bus.O_DestValue, bus.O_CCValue, bus.O_IR); end
        rst = 1'b0;
        drive(OP_LDW, 32'h30, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0, CC_Z);
        run_op(ns, nb);
        n_chk++; if (ns !== 2) begin n_fail++; $display("FAIL rstmid_idle: got %0d stalls want 2", ns); end
        n_chk++; if (bus.O_DestValue !== 32'h77 || bus.O_CCValue !== CC_P) begin
            n_fail++; $display("FAIL rstmid_mem: got %h/%b want 77/001", bus.O_DestValue, bus.O_CCValue); end
    endtask

    task automatic test_wrap();
        drive(OP_STW, 32'h1008, 32'h0BADF00D, 1'b1, 1'b0, 1'b0, 32'h0, CC_Z);
        run_op(ns, nb);
        drive(OP_LDW, 32'h8, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0, CC_Z);
        run_op(ns, nb);
        n_chk++; if (bus.O_DestValue !== 32'h0BADF00D || bus.O_CCValue !== CC_P) begin
            n_fail++; $display("FAIL wrap: got %h/%b want 0badf00d/001", bus.O_DestValue, bus.O_CCValue); end
        drive(OP_LDW, 32'hB, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, CC_N);
        run_op(ns, nb);
        n_chk++; if (bus.O_DestValue !== 32'h0BADF00D || bus.O_CCValue !== CC_N) begin
            n_fail++; $display("FAIL lowbits: got %h/%b want 0badf00d/100", bus.O_DestValue, bus.O_CCValue); end
    endtask

    task automatic test_zero_cc();
        drive(OP_STW, 32'h40, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, CC_P);
        run_op(ns, nb);
        drive(OP_LDW, 32'h40, 32'h0, 1'b1, 1'b1, 1'b1, 32'h5, CC_P);
        run_op(ns, nb);
        n_chk++; if (bus.O_DestValue !== 32'h0 || bus.O_CCValue !== CC_Z) begin
            n_fail++; $display("FAIL zero_cc: got %h/%b want 0/010", bus.O_DestValue, bus.O_CCValue); end
    endtask

    task automatic test_back_to_back();
        drive(OP_LDW, 32'h10, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, CC_Z);
        run_op(ns, nb);
        n_chk++; if (bus.O_DestValue !== 32'hDEADBEEF || ns !== 2) begin
            n_fail++; $display("FAIL b2b_first: got %h/%0d want deadbeef/2", bus.O_DestValue, ns); end
        drive(OP_LDW, 32'h20, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, CC_Z);
        run_op(ns, nb);
        n_chk++; if (bus.O_DestValue !== 32'hCAFE0001 || ns !== 2) begin
            n_fail++; $display("FAIL b2b_second: got %h/%0d want cafe0001/2", bus.O_DestValue, ns); end
    endtask

`ifdef MEM_STAGE_BYTE_OPS_EN
    task automatic test_byte_ops();
        drive(OP_STW, 32'h0, 32'h11223344, 1'b1, 1'b0, 1'b0, 32'h0, CC_Z);
        run_op(ns, nb);
        drive(OP_STB, 32'h1, 32'h000000FF, 1'b1, 1'b0, 1'b0, 32'h0, CC_Z);
        run_op(ns, nb);
        n_chk++; if (ns !== 2) begin n_fail++; $display("FAIL stb_stalls: got %0d want 2", ns); end
        drive(OP_LDW, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, CC_Z);
        run_op(ns, nb);
        n_chk++; if (bus.O_DestValue !== 32'h1122FF44) begin n_fail++; $display("FAIL stb_lane: got %h want 1122ff44", bus.O_DestValue); end
        drive(OP_LDB, 32'h1, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0, CC_Z);
        run_op(ns, nb);
        n_chk++; if (bus.O_DestValue !== 32'hFFFFFFFF || bus.O_CCValue !== CC_N) begin
            n_fail++; $display("FAIL ldb_neg: got %h/%b want ffffffff/100", bus.O_DestValue, bus.O_CCValue); end
        drive(OP_LDB, 32'h3, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0, CC_Z);
        run_op(ns, nb);
        n_chk++; if (bus.O_DestValue !== 32'h11 || bus.O_CCValue !== CC_P) begin
            n_fail++; $display("FAIL ldb_pos: got %h/%b want 11/001", bus.O_DestValue, bus.O_CCValue); end
    endtask
`else
    task automatic test_byte_ops();
        drive(OP_LDB, 32'h1, 32'h0, 1'b1, 1'b1, 1'b0, 32'hABCD, CC_P);
        @(posedge clk);
        n_chk++; if (bus.O_MemStallSignal !== 1'b0) begin n_fail++; $display("FAIL ldb_stall: got %b want 0", bus.O_MemStallSignal); end
        tick();
        n_chk++; if (bus.O_DestValue !== 32'hABCD || bus.O_MEM_Valid !== 1'b1) begin
            n_fail++; $display("FAIL ldb_pass: got %h/%b want abcd/1", bus.O_DestValue, bus.O_MEM_Valid); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.I_LOCK = 1'b0;
        drive(OP_ADD, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 3'b000);
        tick();
        test_reset();
        test_store_load();
        test_latency();
        test_lock();
        test_passthrough();
        test_invalid_store();
        test_reset_mid();
        test_wrap();
        test_zero_cc();
        test_back_to_back();
        test_byte_ops();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
